// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Instruction-fetch sequencer with stall, branch redirect,
//             halt/resume and a single registered instruction slot.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int N = 6,
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] PC_Output,
  output logic [N-1:0] PC_Input,
  output logic         Control,
  input  logic [W-1:0] Imem_Data,
  output logic [W-1:0] Instr,
  output logic [N-1:0] Instr_PC,
  output logic         Instr_Valid,
  input  logic         Instr_Ready,
  input  logic         Branch_Taken,
  input  logic [N-1:0] Branch_Offset,
  input  logic         Halt_Req,
  input  logic         Resume
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next_state;
  logic   w_capture;
  logic   w_flush;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      Instr       <= '0;
      Instr_PC    <= '0;
      Instr_Valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        Instr       <= Imem_Data;
        Instr_PC    <= PC_Output;
        Instr_Valid <= 1'b1;
      end else if (w_flush) begin
        Instr_Valid <= 1'b0;
      end
    end
  end

  // Halt beats branch beats stall; a held PC is presented back unchanged.
  always_comb begin
    w_next_state = r_state;
    Control      = 1'b0;
    PC_Input     = PC_Output;
    w_capture    = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH, S_WAIT: begin
        if (Halt_Req) begin
          w_flush      = 1'b1;
          w_next_state = S_HALT;
        end else if (Branch_Taken && Instr_Valid) begin
          Control      = 1'b1;
          PC_Input     = Instr_PC + C_ONE + Branch_Offset;
          w_flush      = 1'b1;
          w_next_state = S_FETCH;
        end else if (Instr_Valid && !Instr_Ready) begin
          w_next_state = S_WAIT;
        end else begin
          Control      = 1'b1;
          PC_Input     = PC_Output + C_ONE;
          w_capture    = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_HALT: begin
        if (Resume && !Halt_Req) begin
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
